pipe_hazard_seq: RTL and testbench
==================================

Name: pipe_hazard_seq

Overview:
- Central sequencer for the five-stage pipeline's inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Resolves four conditions each cycle: load-use hazards, EX-stage control-flow flushes, multi-cycle data-memory waits, and debug halt/single-step.
- Drives a per-stage write-enable and clear plus the PC write-enable.
- Registered state: FSM, timeout counter, optional perf counters. Control outputs are combinational from state and inputs.

Parameters:
- TMO_W, 8, width of the data-memory wait timeout counter.
- TMO_MAX, 200, wait cycles before mem_tmo fires; must be < 2^TMO_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- id_rs1  in  5  rs1 of ID instruction
- id_rs2  in  5  rs2 of ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_jump  in  1  EX resolved taken branch/jump/trap redirect
- mem_req  in  1  MEM stage instruction accesses data memory
- dm_ready  in  1  data memory completes access this cycle
- halt_req  in  1  debug halt request (level)
- step  in  1  single-step pulse, honoured only in HALT
- pc_wen  out  1  PC write enable
- if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  stage write enables
- if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear  out  1 each  load bubble (all-zero) on next edge
- state_o  out  2  current FSM state
- mem_tmo  out  1  one-cycle pulse when wait timeout expires

Behaviour:
- Clear rule: every clear_x=1 is accompanied by wen_x=1.
- During reset (rstn=0, asynchronous):
  - State is RUN (2'd0); timeout counter is 0; mem_tmo=0.
  - All wen outputs are 0; all clear outputs are 1.
  - After release, normal evaluation starts on the first edge.
- States: RUN=0, MWAIT=1, HALT=2. Encoding 3 is illegal and returns to RUN on the next edge.
- Load-use hazard (LU) = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN output priority, highest first:
  1. mem_req & !dm_ready:
     - All wen=0, except mem_wb_wen=1 with mem_wb_clear=1.
     - Next state MWAIT; timeout counter loads 1.
     - ex_jump and LU are ignored this cycle; EX/ID are frozen and present them again later.
  2. ex_jump:
     - All wen=1; if_id_clear=1, id_ex_clear=1.
     - Overrides LU, because the hazarding ID instruction is squashed.
  3. LU:
     - pc_wen=0, if_id_wen=0; id_ex_wen=1 with id_ex_clear=1; ex_mem_wen=1, mem_wb_wen=1.
     - Exactly one bubble per hazard.
  4. Otherwise: all wen=1, no clears.
- RUN to HALT: halt_req=1 and case 1 not active. The current cycle still advances per cases 2-4; HALT applies from the next cycle.
- MWAIT:
  - dm_ready=0: outputs as RUN case 1; counter increments.
  - When the counter equals TMO_MAX: mem_tmo=1 for one cycle, the stage is forced to advance as if dm_ready, state goes to RUN.
  - dm_ready=1: outputs are evaluated as RUN cases 2-4 (all stages advance); next state RUN, or HALT if halt_req; counter clears.
- HALT:
  - All wen=0, no clears.
  - step=1: outputs for one cycle as RUN evaluation. If that evaluation hits case 1, go to MWAIT and return to HALT after completion if halt_req is still 1.
  - halt_req=0: next state RUN.
- Reset mid-MWAIT or mid-HALT: immediate return to RUN, counter cleared, no mem_tmo.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall[31:0], perf_flush[31:0], perf_wait[31:0].
  - perf_stall increments on each LU bubble.
  - perf_flush increments on each ex_jump flush.
  - perf_wait increments each cycle in MWAIT.
  - All are cleared by rstn, saturate at 32'hFFFF_FFFF and never wrap.
- Not defined: ports absent, no counter logic.

Test Plan:
- LU: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_wen=0, if_id_wen=0, id_ex_clear=1 that cycle; next cycle (LU low) all wen=1.
- LU to x0: ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall.
- ex_jump=1 together with LU -> if_id_clear=id_ex_clear=1, pc_wen=1, no stall.
- mem_req=1, dm_ready low for 3 cycles then high -> state_o=1 for 3 cycles with ex_mem_wen=0 and mem_wb_clear=1; all wen=1 in the dm_ready cycle; state_o=0 after.
- TMO_MAX=4, dm_ready never asserted -> mem_tmo pulse exactly once, 4 cycles after entering MWAIT; then RUN.
- halt_req=1, then step pulse, then halt_req=0 -> state_o=2; exactly one cycle with all wen=1; state_o=0 after release. rstn pulsed low mid-HALT -> all clears=1 asynchronously, state_o=0.

Source files
------------

// File: rtl/pipe_hazard_seq.sv
// -----------------------------------------------------------------------------
// pipe_hazard_seq
//   Central sequencer for a five-stage pipeline. It drives the PC write enable
//   plus a write enable and a bubble-clear for each inter-stage register
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it resolves, in priority order,
//   data-memory waits, EX-stage redirects, load-use hazards, and debug
//   halt/single-step.
//
//   Registered state: FSM, data-memory wait timeout counter and, optionally,
//   performance counters. All control outputs are combinational from state and
//   inputs.
//
// Parameters
//   TMO_W    width of the wait timeout counter
//   TMO_MAX  wait cycles before mem_tmo fires (1 .. 2^TMO_W-1)
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   ex_is_load, ex_rd         EX instruction is a load / its destination
//   id_rs1, id_rs2            ID instruction source registers
//   id_use_rs1, id_use_rs2    ID instruction actually reads rs1 / rs2
//   ex_jump                   EX resolved a taken redirect
//   mem_req, dm_ready         MEM stage accesses memory / access completes
//   halt_req, step            debug halt (level) / single-step pulse
//   pc_wen, *_wen             write enables
//   *_clear                   load an all-zero bubble on the next edge
//   state_o                   current FSM state (RUN=0, MWAIT=1, HALT=2)
//   mem_tmo                   one-cycle pulse when a memory wait times out
//
// Optional feature (macro PIPE_HAZARD_PERF_EN)
//   Adds saturating 32-bit counters perf_stall, perf_flush and perf_wait.
// -----------------------------------------------------------------------------
module pipe_hazard_seq #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_jump,
  input  logic        mem_req,
  input  logic        dm_ready,
  input  logic        halt_req,
  input  logic        step,
  output logic        pc_wen,
  output logic        if_id_wen,
  output logic        id_ex_wen,
  output logic        ex_mem_wen,
  output logic        mem_wb_wen,
  output logic        if_id_clear,
  output logic        id_ex_clear,
  output logic        ex_mem_clear,
  output logic        mem_wb_clear,
  output logic [1:0]  state_o,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_wait,
`endif
  output logic        mem_tmo
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Bit order of the packed control vectors: {pc, if_id, id_ex, ex_mem, mem_wb}
  // for enables and {if_id, id_ex, ex_mem, mem_wb} for clears.
  localparam logic [4:0] WEN_ALL   = 5'b11111;
  localparam logic [4:0] WEN_NONE  = 5'b00000;
  localparam logic [4:0] WEN_MEMST = 5'b00001;  // only MEM/WB moves (bubble)
  localparam logic [4:0] WEN_LU    = 5'b00111;  // PC and IF/ID hold
  localparam logic [3:0] CLR_NONE  = 4'b0000;
  localparam logic [3:0] CLR_ALL   = 4'b1111;
  localparam logic [3:0] CLR_JMP   = 4'b1100;
  localparam logic [3:0] CLR_LU    = 4'b0100;
  localparam logic [3:0] CLR_MEMST = 4'b0001;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic [4:0] wen;
  logic [3:0] clr;
  logic       tmo;
  logic       lu;
  logic       mem_stall;
  logic [4:0] adv_wen;
  logic [3:0] adv_clr;
  logic       use_adv;

  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  assign mem_stall = mem_req && !dm_ready;

  // Outputs when the pipeline is allowed to advance (redirect, bubble or
  // plain flow). A redirect wins over a load-use hazard because the hazarding
  // ID instruction is squashed anyway.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    adv_wen = WEN_ALL;
    adv_clr = CLR_NONE;
    if (ex_jump) begin
      adv_clr = CLR_JMP;
    end else if (lu) begin
      adv_wen = WEN_LU;
      adv_clr = CLR_LU;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen     = WEN_NONE;
    clr     = CLR_NONE;
    tmo     = 1'b0;
    use_adv = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          // EX/ID are frozen, so a pending jump or hazard is seen again later.
          wen     = WEN_MEMST;
          clr     = CLR_MEMST;
          state_d = MWAIT;
          cnt_d   = TMO_W'(1);
        end else begin
          use_adv = 1'b1;
          state_d = halt_req ? HALT : RUN;
          cnt_d   = '0;
        end
      end

      MWAIT: begin
        if (dm_ready) begin
          use_adv = 1'b1;
          state_d = halt_req ? HALT : RUN;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LIM) begin
          // Give up on the access: advance as if it had completed.
          tmo     = 1'b1;
          use_adv = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          wen   = WEN_MEMST;
          clr   = CLR_MEMST;
          cnt_d = cnt_q + 1'b1;
        end
      end

      HALT: begin
        cnt_d   = '0;
        state_d = halt_req ? HALT : RUN;
        if (step) begin
          if (mem_stall) begin
            // Finish the access in MWAIT; its exit re-checks halt_req.
            wen     = WEN_MEMST;
            clr     = CLR_MEMST;
            state_d = MWAIT;
            cnt_d   = TMO_W'(1);
          end else begin
            use_adv = 1'b1;
          end
        end
      end

      default: begin
        // Illegal encoding: hold everything and recover to RUN.
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (use_adv) begin
      wen = adv_wen;
      clr = adv_clr;
    end

    // Reset is visible on the outputs immediately, not at the next edge.
    if (!rstn) begin
      wen = WEN_NONE;
      clr = CLR_ALL;
      tmo = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen} = wen;
  assign {if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear} = clr;
  assign state_o = state_q;
  assign mem_tmo = tmo;

`ifdef PIPE_HAZARD_PERF_EN
  logic stall_evt, flush_evt, wait_evt;

  // Count only the events that actually reach the pipeline this cycle.
  assign flush_evt = rstn && use_adv && ex_jump;
  assign stall_evt = rstn && use_adv && !ex_jump && lu;
  assign wait_evt  = rstn && (state_q == MWAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_wait  <= '0;
    end else begin
      if (stall_evt && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
      if (flush_evt && (perf_flush != 32'hFFFF_FFFF)) perf_flush <= perf_flush + 32'd1;
      if (wait_evt  && (perf_wait  != 32'hFFFF_FFFF)) perf_wait  <= perf_wait  + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_seq
//   Directed vectors for pipe_hazard_seq (TMO_MAX=4). The driver applies one
//   vector per cycle shortly after the rising edge and queues the hand-computed
//   expected outputs {wen[4:0], clear[3:0], state[1:0], mem_tmo}; the monitor
//   pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_seq;

  localparam logic [4:0] W_ALL  = 5'b11111;
  localparam logic [4:0] W_NONE = 5'b00000;
  localparam logic [4:0] W_MEM  = 5'b00001;
  localparam logic [4:0] W_LU   = 5'b00111;
  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_ALL  = 4'b1111;
  localparam logic [3:0] C_JMP  = 4'b1100;
  localparam logic [3:0] C_LU   = 4'b0100;
  localparam logic [3:0] C_MEM  = 4'b0001;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ex_is_load, id_use_rs1, id_use_rs2, ex_jump;
  logic       mem_req, dm_ready, halt_req, step;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic       if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
  logic [1:0] state_o;
  logic       mem_tmo;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_wait;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  pipe_hazard_seq #(.TMO_W(8), .TMO_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_jump(ex_jump), .mem_req(mem_req), .dm_ready(dm_ready),
    .halt_req(halt_req), .step(step),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
    .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
    .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
    .state_o(state_o),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_wait(perf_wait),
`endif
    .mem_tmo(mem_tmo)
  );

  task automatic check(input string name, input logic [11:0] got,
                       input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got wen=%b clr=%b st=%0d tmo=%b, want wen=%b clr=%b st=%0d tmo=%b",
               name, got[11:7], got[6:3], got[2:1], got[0],
               exp[11:7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(),
            {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
             if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear,
             state_o, mem_tmo},
            exp_q.pop_front());
    end
  end

  // Hazard-related ID/EX fields: {ex_is_load, ex_rd, id_rs1, id_rs2, use1, use2}
  task automatic apply(input string name, input logic rst,
                       input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic jmp, input logic mreq, input logic dmr,
                       input logic hlt, input logic stp,
                       input logic [4:0] ew, input logic [3:0] ec,
                       input logic [1:0] es, input logic et);
    @(posedge clk);
    #1;
    rstn = rst; ex_is_load = ld; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; ex_jump = jmp; mem_req = mreq;
    dm_ready = dmr; halt_req = hlt; step = stp;
    exp_q.push_back({ew, ec, es, et});
    name_q.push_back(name);
  endtask

  task automatic idle(input string name, input logic hlt,
                      input logic [4:0] ew, input logic [3:0] ec,
                      input logic [1:0] es);
    apply(name, 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, hlt, 0, ew, ec, es, 0);
  endtask

  initial begin
    rstn = 1'b0; ex_is_load = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_jump = 0; mem_req = 0; dm_ready = 0;
    halt_req = 0; step = 0;

    apply("reset", 1'b0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, W_NONE, C_ALL, 2'd0, 0);
    idle("run_idle", 0, W_ALL, C_NONE, 2'd0);
    // Load-use hazards
    apply("lu_rs2", 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 0, 0, W_LU, C_LU, 2'd0, 0);
    idle("lu_after", 0, W_ALL, C_NONE, 2'd0);
    apply("lu_rs1", 1, 1, 5'd7, 5'd7, 5'd3, 1, 1, 0, 0, 0, 0, 0, W_LU, C_LU, 2'd0, 0);
    apply("lu_x0", 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 0, W_ALL, C_NONE, 2'd0, 0);
    apply("lu_unused", 1, 1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0, 0, 0, 0, W_ALL, C_NONE, 2'd0, 0);
    apply("lu_not_load", 1, 0, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, 0, 0, 0, W_ALL, C_NONE, 2'd0, 0);
    apply("jump_over_lu", 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, 0, 0, W_ALL, C_JMP, 2'd0, 0);
    // Memory wait: 3 low cycles, then ready (jump during entry is ignored)
    apply("mw_enter", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, W_MEM, C_MEM, 2'd0, 0);
    apply("mw_wait1", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, W_MEM, C_MEM, 2'd1, 0);
    apply("mw_wait2", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, W_MEM, C_MEM, 2'd1, 0);
    apply("mw_ready", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, W_ALL, C_NONE, 2'd1, 0);
    idle("mw_back_run", 0, W_ALL, C_NONE, 2'd0);
    // Timeout at TMO_MAX=4
    apply("tmo_enter", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, W_MEM, C_MEM, 2'd0, 0);
    apply("tmo_c1", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, W_MEM, C_MEM, 2'd1, 0);
    apply("tmo_c2", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, W_MEM, C_MEM, 2'd1, 0);
    apply("tmo_c3", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, W_MEM, C_MEM, 2'd1, 0);
    apply("tmo_fire", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, W_ALL, C_NONE, 2'd1, 1);
    idle("tmo_after", 0, W_ALL, C_NONE, 2'd0);
    // Ready together with a redirect: flush applies on completion
    apply("mwj_enter", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, W_MEM, C_MEM, 2'd0, 0);
    apply("mwj_ready", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0, 0, W_ALL, C_JMP, 2'd1, 0);
    // Halt and single-step
    idle("halt_req_run", 1, W_ALL, C_NONE, 2'd0);
    idle("halted", 1, W_NONE, C_NONE, 2'd2);
    apply("step_plain", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, W_ALL, C_NONE, 2'd2, 0);
    idle("halted2", 1, W_NONE, C_NONE, 2'd2);
    apply("step_lu", 1, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0, 0, 1, 1, W_LU, C_LU, 2'd2, 0);
    apply("step_mem", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 1, W_MEM, C_MEM, 2'd2, 0);
    apply("step_mw_ready", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, 0, W_ALL, C_NONE, 2'd1, 0);
    idle("rehalted", 1, W_NONE, C_NONE, 2'd2);
    idle("halt_release", 0, W_NONE, C_NONE, 2'd2);
    idle("run_after_halt", 0, W_ALL, C_NONE, 2'd0);
    // Asynchronous reset in the middle of HALT
    idle("halt_again", 1, W_ALL, C_NONE, 2'd0);
    idle("halted3", 1, W_NONE, C_NONE, 2'd2);
    apply("reset_in_halt", 1'b0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, W_NONE, C_ALL, 2'd0, 0);
    idle("run_after_rst", 0, W_ALL, C_NONE, 2'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
